// File: rtl/sd_cmd_arb_pkg.sv
// Shared types and widths for the SD command arbiter and its round-robin picker.
package sd_cmd_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } arb_state_t;

  localparam int CMD_INDEX_W = 6;
  localparam int CMD_ARG_W   = 32;
  localparam int RSP_W       = 128;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_picker
  import sd_cmd_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic            found;
  logic [ID_W-1:0] idx_w;

  always_comb begin
    winner    = '0;
    found     = 1'b0;
    idx_w     = '0;
    any_valid = |req_valid;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx_w]) begin
        winner = idx_w;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter sharing one SD command controller between NUM_REQ requesters.
// Define CMD_ARB_TIMEOUT_EN to build the WAIT-state timeout timer.
//
// state    | meaning
// ST_IDLE  | arbitrate pending requests, latch winner command
// ST_ISSUE | present new_command to the controller for one cycle
// ST_WAIT  | wait for command_complete (or timeout when enabled)
// ST_DONE  | wait for the controller to drop command_complete
module cmd_arbiter
  import sd_cmd_arb_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [CMD_INDEX_W*NUM_REQ-1:0] req_index,
  input  logic [CMD_ARG_W*NUM_REQ-1:0] req_argument,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_timeout,
  output logic [RSP_W-1:0]             rsp_data,
  output logic                         new_command,
  output logic [CMD_INDEX_W-1:0]       cmd_index,
  output logic [CMD_ARG_W-1:0]         cmd_argument,
  input  logic                         command_complete,
  input  logic [RSP_W-1:0]             response,
  output logic                         busy
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t state, state_nx;
  logic [ID_W-1:0]        cur, cur_nx, rr_ptr, rr_ptr_nx, pick_id;
  logic                   pick_any;
  logic [NUM_REQ-1:0]     grant_nx, done_nx, timeout_nx;
  logic                   new_cmd_nx;
  logic [CMD_INDEX_W-1:0] idx_nx;
  logic [CMD_ARG_W-1:0]   arg_nx;
  logic [RSP_W-1:0]       rsp_nx;
  logic                   timer_hit;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

`ifdef CMD_ARB_TIMEOUT_EN
  logic [15:0] timer;

  // Counts WAIT cycles from 0; hitting TIMEOUT_CYCLES-1 forces the exit, so it never wraps.
  always_ff @(posedge clock) begin
    if (reset)
      timer <= '0;
    else if (state == ST_ISSUE)
      timer <= '0;
    else if (state == ST_WAIT)
      timer <= timer + 16'd1;
  end

  assign timer_hit = (timer == TIMEOUT_CYCLES - 16'd1);
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
  assign timer_hit      = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    rr_ptr_nx  = rr_ptr;
    idx_nx     = cmd_index;
    arg_nx     = cmd_argument;
    rsp_nx     = rsp_data;
    grant_nx   = '0;
    done_nx    = '0;
    timeout_nx = '0;
    new_cmd_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          cur_nx   = pick_id;
          idx_nx   = req_index[int'(pick_id)*CMD_INDEX_W +: CMD_INDEX_W];
          arg_nx   = req_argument[int'(pick_id)*CMD_ARG_W +: CMD_ARG_W];
          grant_nx = NUM_REQ'(1) << pick_id;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        new_cmd_nx = 1'b1;
        state_nx   = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats a coincident timeout.
        if (command_complete) begin
          rsp_nx   = response;
          done_nx  = NUM_REQ'(1) << cur;
          state_nx = ST_DONE;
        end else if (timer_hit) begin
          timeout_nx = NUM_REQ'(1) << cur;
          state_nx   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!command_complete) begin
          rr_ptr_nx = (int'(cur) == NUM_REQ - 1) ? '0 : cur + 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur          <= '0;
      rr_ptr       <= '0;
      req_grant    <= '0;
      req_done     <= '0;
      req_timeout  <= '0;
      rsp_data     <= '0;
      new_command  <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cur          <= cur_nx;
      rr_ptr       <= rr_ptr_nx;
      req_grant    <= grant_nx;
      req_done     <= done_nx;
      req_timeout  <= timeout_nx;
      rsp_data     <= rsp_nx;
      new_command  <= new_cmd_nx;
      cmd_index    <= idx_nx;
      cmd_argument <= arg_nx;
      busy         <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: transaction-level model checked every cycle plus directed cases.
module tb_cmd_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;
`ifdef CMD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [6*N-1:0] req_index = '0;
  logic [32*N-1:0] req_argument = '0;
  logic [N-1:0]   req_grant, req_done, req_timeout;
  logic [127:0]   rsp_data;
  logic           new_command;
  logic [5:0]     cmd_index;
  logic [31:0]    cmd_argument;
  logic           command_complete = 1'b0;
  logic [127:0]   response = '0;
  logic           busy;

  always #5 clock = ~clock;

  cmd_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16'(TO))
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_index        (req_index),
    .req_argument     (req_argument),
    .req_grant        (req_grant),
    .req_done         (req_done),
    .req_timeout      (req_timeout),
    .rsp_data         (rsp_data),
    .new_command      (new_command),
    .cmd_index        (cmd_index),
    .cmd_argument     (cmd_argument),
    .command_complete (command_complete),
    .response         (response),
    .busy             (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: expected outputs after each edge, derived from the arbitration rules.
  logic [N-1:0] e_grant = '0, e_done = '0, e_to = '0;
  logic         e_new = 1'b0, e_busy = 1'b0;
  logic [5:0]   e_idx = '0;
  logic [31:0]  e_arg = '0;
  logic [127:0] e_rsp = '0;
  bit           model_on = 1'b0;
  int           last = N - 1;

  task automatic tick(output bit ab);
    @(posedge clock);
    e_grant = '0; e_done = '0; e_to = '0; e_new = 1'b0; ab = 1'b0;
    if (reset) begin
      e_busy = 1'b0; e_idx = '0; e_arg = '0; e_rsp = '0;
      last = N - 1; model_on = 1'b1; ab = 1'b1;
    end
  endtask

  initial begin : model
    bit ab;
    bit fin;
    int w;
    int cnt;
    forever begin
      tick(ab);
      if (ab || !model_on || req_valid == '0) continue;
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
      e_grant = N'(1) << w;
      e_busy  = 1'b1;
      e_idx   = req_index[6*w +: 6];
      e_arg   = req_argument[32*w +: 32];
      tick(ab);
      if (ab) continue;
      e_new = 1'b1;
      cnt = 0; fin = 1'b0;
      while (!fin) begin
        tick(ab);
        if (ab) break;
        if (command_complete) begin
          e_rsp = response; e_done = N'(1) << w; fin = 1'b1;
        end else if (TO_EN && cnt == TO - 1) begin
          e_to = N'(1) << w; fin = 1'b1;
        end
        cnt++;
      end
      if (ab) continue;
      fin = 1'b0;
      while (!fin) begin
        tick(ab);
        if (ab) break;
        if (!command_complete) begin
          e_busy = 1'b0; last = w; fin = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("grant", req_grant, e_grant);
      chk("done", req_done, e_done);
      chk("timeout", req_timeout, e_to);
      chk("new_command", new_command, e_new);
      chk("busy", busy, e_busy);
      chk("cmd_index", cmd_index, e_idx);
      chk("cmd_argument", cmd_argument, e_arg);
      chk("rsp_data", rsp_data, e_rsp);
    end
  end

  // Event log for the directed literal checks.
  int grant_cyc = -1, done_cyc = -1, to_cyc = -1, done_cnt = 0, to_cnt = 0;
  int glog[$];

  always @(negedge clock) begin
    if (req_grant != '0) begin
      grant_cyc = cyc;
      for (int i = 0; i < N; i++) if (req_grant[i]) glog.push_back(i);
    end
    if (req_done != '0) begin done_cyc = cyc; done_cnt++; end
    if (req_timeout != '0) begin to_cyc = cyc; to_cnt++; end
  end

  task automatic request(input int id, input logic [5:0] idx, input logic [31:0] arg);
    req_valid[id] = 1'b1;
    req_index[6*id +: 6] = idx;
    req_argument[32*id +: 32] = arg;
  endtask

  task automatic wait_new(input bit hold, output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clock);
      if (!hold) req_valid = req_valid & ~req_grant;
      if (new_command) at = cyc;
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL new_command_wait: got none want pulse within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle_wait: got busy want idle within 40 cycles");
    end
  endtask

  task automatic respond(input int delay, input int hold, input logic [127:0] rsp);
    repeat (delay) @(negedge clock);
    command_complete = 1'b1;
    response = rsp;
    repeat (hold) @(negedge clock);
    command_complete = 1'b0;
    response = ~rsp;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, n, d0, to0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", rsp_data, 128'h0);
    chk("rst_new", new_command, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // Single request from requester 0.
    t0 = cyc; d0 = done_cnt;
    request(0, 6'd17, 32'h0000_0200);
    wait_new(1'b0, n);
    chk("t1_grant_lat", grant_cyc - t0, 1);
    chk("t1_newcmd_lat", n - t0, 2);
    chk("t1_index", cmd_index, 6'd17);
    chk("t1_arg", cmd_argument, 32'h0000_0200);
    respond(6, 1, 128'hDEAD_BEEF);
    wait_idle();
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_done_lat", done_cyc - n, 7);
    chk("t1_rsp", rsp_data, 128'hDEAD_BEEF);

    // Requester 1 granted, reset mid-WAIT: rr pointer must return to 0.
    d0 = done_cnt; to0 = to_cnt;
    request(1, 6'd2, 32'h1111_2222);
    wait_new(1'b0, n);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_grant", req_grant, 2'b00);
    chk("rst_mid_index", cmd_index, 6'd0);
    chk("rst_mid_rsp", rsp_data, 128'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_mid_no_pulse", (done_cnt - d0) + (to_cnt - to0), 0);

    // Contention: both held high for four commands.
    glog.delete();
    request(0, 6'd3, 32'hA0A0_0000);
    request(1, 6'd12, 32'hB1B1_0001);
    for (int i = 0; i < 4; i++) begin
      wait_new(1'b1, n);
      repeat (2) @(negedge clock);
      command_complete = 1'b1;
      response = 128'h100 + 128'(i);
      if (i == 3) req_valid = '0;
      @(negedge clock);
      command_complete = 1'b0;
    end
    wait_idle();
    chk("t3_grants", glog.size(), 4);
    if (glog.size() == 4)
      for (int i = 0; i < 4; i++) chk("t3_order", glog[i], i % 2);

    // Complete held three cycles after capture.
    d0 = done_cnt;
    request(1, 6'd7, 32'h0000_0007);
    wait_new(1'b0, n);
    repeat (2) @(negedge clock);
    command_complete = 1'b1;
    response = 128'hC0FFEE;
    repeat (4) @(negedge clock);
    chk("t4_busy_held", busy, 1'b1);
    command_complete = 1'b0;
    @(negedge clock);
    chk("t4_busy_drop", busy, 1'b0);
    chk("t4_done_cnt", done_cnt - d0, 1);
    chk("t4_done_lat", done_cyc - n, 3);

    // Complete arrives on the last timer cycle: completion wins.
    d0 = done_cnt; to0 = to_cnt;
    request(0, 6'd9, 32'h0000_0009);
    wait_new(1'b0, n);
    respond(7, 1, 128'h5A5A_0000_1234);
    wait_idle();
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_to_cnt", to_cnt - to0, 0);
    chk("t5_done_lat", done_cyc - n, 8);
    chk("t5_rsp", rsp_data, 128'h5A5A_0000_1234);

    d0 = done_cnt; to0 = to_cnt;
    request(1, 6'd13, 32'h0000_000D);
    wait_new(1'b0, n);
`ifdef CMD_ARB_TIMEOUT_EN
    // Controller never completes: abort after TO wait cycles.
    wait_idle();
    chk("t6_to_cnt", to_cnt - to0, 1);
    chk("t6_to_lat", to_cyc - n, TO);
    chk("t6_done_cnt", done_cnt - d0, 0);
    chk("t6_rsp_kept", rsp_data, 128'h5A5A_0000_1234);
`else
    // Without the timer the arbiter waits indefinitely for completion.
    repeat (20) @(negedge clock);
    chk("t6_still_busy", busy, 1'b1);
    chk("t6_no_timeout", to_cnt - to0, 0);
    respond(0, 1, 128'h6666);
    wait_idle();
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_rsp", rsp_data, 128'h6666);
`endif

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
